// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the select of a 2:1 mux (sel=1 routes b,
// sel=0 routes c). Bounded hold time under contention, registered outputs.
module mux_sel_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_b,
  input  logic             req_c,
  output logic             sel,
  output logic             gnt_b,
  output logic             gnt_c,
  output logic             busy,
  output logic [CNT_W-1:0] hold_cnt
);

  typedef enum logic [1:0] {IDLE, GNT_B, GNT_C} state_t;

  // Pre-emption point: the owner has held for MAX_HOLD cycles once the
  // counter reaches MAX_HOLD-1.
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sel_nxt;
  logic             last, last_nxt;   // 1 = B served last, 0 = C

  // Next-state, counter, select and last-served decisions.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req_b && req_c) state_nxt = last ? GNT_C : GNT_B;
        else if (req_b)     state_nxt = GNT_B;
        else if (req_c)     state_nxt = GNT_C;
      end
      GNT_B: begin
        if (!req_b)                           state_nxt = req_c ? GNT_C : IDLE;
        else if (req_c && hold_cnt == HOLD_LIM) state_nxt = GNT_C;
      end
      GNT_C: begin
        if (!req_c)                           state_nxt = req_b ? GNT_B : IDLE;
        else if (req_b && hold_cnt == HOLD_LIM) state_nxt = GNT_B;
      end
      default: state_nxt = IDLE;
    endcase

    // Counter restarts on any ownership change, saturates while held.
    cnt_nxt = hold_cnt;
    if (state_nxt != state)                        cnt_nxt = '0;
    else if (state != IDLE && hold_cnt != CNT_MAX) cnt_nxt = hold_cnt + CNT_W'(1);

    // Select and last-served only move on entry to a grant; IDLE keeps
    // the mux steady.
    sel_nxt  = sel;
    last_nxt = last;
    if (state_nxt == GNT_B) begin
      sel_nxt  = 1'b1;
      last_nxt = 1'b1;
    end else if (state_nxt == GNT_C) begin
      sel_nxt  = 1'b0;
      last_nxt = 1'b0;
    end
  end

  // State and registered outputs; grants decoded from next state so they
  // come straight out of flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      sel      <= 1'b0;
      last     <= 1'b0;
      gnt_b    <= 1'b0;
      gnt_c    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= cnt_nxt;
      sel      <= sel_nxt;
      last     <= last_nxt;
      gnt_b    <= (state_nxt == GNT_B);
      gnt_c    <= (state_nxt == GNT_C);
      busy     <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter: default MAX_HOLD=4 instance plus a
// MAX_HOLD=1 instance for the per-cycle alternation case.
module tb_mux_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_b, req_c, req_b1, req_c1;
  logic       sel, gnt_b, gnt_c, busy;
  logic       sel1, gnt_b1, gnt_c1, busy1;
  logic [2:0] hold_cnt, hold_cnt1;
  logic [6:0] obs, obs1, exp_v;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  // {sel, gnt_b, gnt_c, busy, hold_cnt}
  assign obs  = {sel, gnt_b, gnt_c, busy, hold_cnt};
  assign obs1 = {sel1, gnt_b1, gnt_c1, busy1, hold_cnt1};

  mux_sel_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .req_b(req_b), .req_c(req_c),
    .sel(sel), .gnt_b(gnt_b), .gnt_c(gnt_c), .busy(busy), .hold_cnt(hold_cnt)
  );

  mux_sel_arbiter #(.MAX_HOLD(1), .CNT_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_b(req_b1), .req_c(req_c1),
    .sel(sel1), .gnt_b(gnt_b1), .gnt_c(gnt_c1), .busy(busy1), .hold_cnt(hold_cnt1)
  );

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0; req_b = 1'b0; req_c = 1'b0;
    #1;
    @(negedge clk); rst_n = 1'b1;
  endtask

  // Drive requests at the falling edge, sample 1ns after the next rising edge.
  task automatic step(input logic b, input logic c);
    @(negedge clk); req_b = b; req_c = c;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    tests++;
    if (obs !== 7'b0) begin
      fails++; $display("FAIL reset_state: got %b want %b", obs, 7'b0);
    end
    tests++;
    if (obs1 !== 7'b0) begin
      fails++; $display("FAIL reset_state_mh1: got %b want %b", obs1, 7'b0);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk); req_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      exp_v = {4'b1101, 3'(i)};
      tests++;
      if (obs !== exp_v) begin
        fails++; $display("FAIL single_b cyc%0d: got %b want %b", i, obs, exp_v);
      end
    end
    step(1'b0, 1'b0);
    tests++;
    if (obs !== 7'b1000_000) begin
      fails++; $display("FAIL single_idle_sel: got %b want %b", obs, 7'b1000_000);
    end
  endtask

  task automatic test_contention();
    do_reset();
    @(negedge clk); req_b = 1'b1; req_c = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      exp_v = ((k / 4) % 2 == 0) ? {4'b1101, 3'(k % 4)} : {4'b0011, 3'(k % 4)};
      tests++;
      if (obs !== exp_v) begin
        fails++; $display("FAIL contention cyc%0d: got %b want %b", k, obs, exp_v);
      end
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    step(1'b0, 1'b1);
    tests++;
    if (obs !== 7'b0011_000) begin
      fails++; $display("FAIL handover_c: got %b want %b", obs, 7'b0011_000);
    end
    step(1'b1, 1'b0);
    tests++;
    if (obs !== 7'b1101_000) begin
      fails++; $display("FAIL handover_b: got %b want %b", obs, 7'b1101_000);
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_tie_prior();
    logic [1:0] reqs [6] = '{2'b01, 2'b00, 2'b11, 2'b00, 2'b10, 2'b00};
    logic [6:0] exps [6] = '{7'b0011_000, 7'b0000_000, 7'b1101_000,
                             7'b1000_000, 7'b1101_000, 7'b1000_000};
    for (int i = 0; i < 6; i++) begin
      step(reqs[i][1], reqs[i][0]);
      tests++;
      if (obs !== exps[i]) begin
        fails++; $display("FAIL tie_prior step%0d: got %b want %b", i, obs, exps[i]);
      end
    end
    step(1'b1, 1'b1);
    tests++;
    if (obs !== 7'b0011_000) begin
      fails++; $display("FAIL tie_prior_c: got %b want %b", obs, 7'b0011_000);
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    tests++;
    if (obs !== 7'b0011_010) begin
      fails++; $display("FAIL pre_reset_gnt_c: got %b want %b", obs, 7'b0011_010);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (obs !== 7'b0) begin
      fails++; $display("FAIL async_reset: got %b want %b", obs, 7'b0);
    end
    req_c = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    step(1'b1, 1'b1);
    tests++;
    if (obs !== 7'b1101_000) begin
      fails++; $display("FAIL post_reset_tie: got %b want %b", obs, 7'b1101_000);
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_maxhold1();
    @(negedge clk); req_b1 = 1'b1; req_c1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      exp_v = (k % 2 == 0) ? 7'b1101_000 : 7'b0011_000;
      tests++;
      if (obs1 !== exp_v) begin
        fails++; $display("FAIL maxhold1 cyc%0d: got %b want %b", k, obs1, exp_v);
      end
    end
    @(negedge clk); req_b1 = 1'b0; req_c1 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; req_b = 1'b0; req_c = 1'b0; req_b1 = 1'b0; req_c1 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_tie_prior();
    test_reset_mid();
    test_maxhold1();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
